// File: rtl/muon_tdc_sequencer_pkg.sv
// Shared types and constants for the muon decay-time TDC sequencer.
//   tdc_state_t : run-control state encoding (also exported on state_dbg)
//   CNT_W_DEF   : default interval counter / result width
//   STATS_W     : width of the optional event/timeout statistics counters
//   sat_inc     : saturating increment for the statistics counters
package muon_tdc_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int STATS_W   = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      MEASURE = 3'd2,
      PUBLISH = 3'd3,
      HOLDOFF = 3'd4
   } tdc_state_t;

   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (v == '1) ? v : v + STATS_W'(1);
   endfunction

endpackage

// File: rtl/muon_tdc_sequencer_if.sv
// Result handshake between the TDC sequencer and the display/readout path.
//   result_data    : measured interval in clocks
//   result_timeout : result is a timeout (saturated interval)
//   result_valid   : result available
//   result_ready   : consumer accepts
// master = sequencer side, slave = consumer side.
interface muon_tdc_sequencer_if
   import muon_tdc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) ();
   logic [CNT_W-1:0] result_data;
   logic             result_timeout;
   logic             result_valid;
   logic             result_ready;

   modport master (output result_data, output result_timeout, output result_valid,
                   input result_ready);
   modport slave  (input result_data, input result_timeout, input result_valid,
                   output result_ready);
endinterface

// File: rtl/muon_tdc_sequencer_rising_edge_detector.sv
// Registered rising-edge detector with async active-low reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   sig        : synchronized input level
//   pulse      : one-cycle registered pulse after each 0->1 transition of sig
// The primed flag suppresses the first sampled cycle after reset so that a
// level already high when reset is released is not reported as an edge.
module rising_edge_detector (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic pulse
);
   logic hist;
   logic primed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist   <= 1'b0;
         primed <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         hist   <= sig;
         primed <= 1'b1;
         pulse  <= sig & ~hist & primed;
      end
   end
endmodule

// File: rtl/muon_tdc_sequencer.sv
// Run-control FSM for the decay-time TDC path: arms, converts start/stop hits
// into an interval count, applies timeout and dead time, and publishes one
// result per event over a valid/ready handshake.
//   clk, rst_n          : 100 MHz system clock, asynchronous active-low reset
//   arm                 : run enable level
//   start_in, stop_in   : synchronized coincidence / stop levels
//   res (master)        : result_data, result_timeout, result_valid, result_ready
//   busy                : high in MEASURE, PUBLISH or HOLDOFF
//   state_dbg           : encoded current state
// Optional build macro MUON_TDC_STATS_EN adds clear_stats, event_count and
// timeout_count (saturating statistics of completed transfers).
//
// state   | meaning
// IDLE    | run disabled, waiting for arm
// ARMED   | waiting for a start edge
// MEASURE | counting interval, waiting for stop or timeout
// PUBLISH | result_valid high, waiting for consumer
// HOLDOFF | dead time after a transfer, all edges ignored
module muon_tdc_sequencer
   import muon_tdc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES  = 230,
   parameter int DEADTIME_CYCLES = 16,
   parameter int CNT_W           = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arm,
   input  logic                 start_in,
   input  logic                 stop_in,
   muon_tdc_sequencer_if.master res,
   output logic                 busy,
   output logic [2:0]           state_dbg
`ifdef MUON_TDC_STATS_EN
   ,
   input  logic                 clear_stats,
   output logic [STATS_W-1:0]   event_count,
   output logic [STATS_W-1:0]   timeout_count
`endif
);
   localparam int HOLD_W = 16;
   localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LOAD   =
      (DEADTIME_CYCLES > 0) ? HOLD_W'(DEADTIME_CYCLES - 1) : '0;

   tdc_state_t        state;
   logic [CNT_W-1:0]  counter;
   logic [CNT_W-1:0]  cnt_inc;
   logic [HOLD_W-1:0] hold_cnt;
   logic              start_p;
   logic              stop_p;
   logic              xfer;

   rising_edge_detector u_start_edge (.clk(clk), .rst_n(rst_n), .sig(start_in), .pulse(start_p));
   rising_edge_detector u_stop_edge  (.clk(clk), .rst_n(rst_n), .sig(stop_in),  .pulse(stop_p));

   // counter holds D-1 on the cycle the stop pulse is seen, so the
   // published interval is counter+1
   assign cnt_inc   = counter + CNT_W'(1);
   assign xfer      = res.result_valid && res.result_ready;
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         counter            <= '0;
         hold_cnt           <= '0;
         busy               <= 1'b0;
         res.result_data    <= '0;
         res.result_timeout <= 1'b0;
         res.result_valid   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) state <= ARMED;
            end
            ARMED: begin
               if (start_p) begin
                  state   <= MEASURE;
                  counter <= '0;
                  busy    <= 1'b1;
               end else if (!arm) begin
                  state <= IDLE;
               end
            end
            MEASURE: begin
               if (stop_p) begin
                  res.result_data    <= cnt_inc;
                  res.result_timeout <= 1'b0;
                  res.result_valid   <= 1'b1;
                  state              <= PUBLISH;
               end else if (start_p) begin
                  counter <= '0;
               end else if (cnt_inc >= TIMEOUT_VAL) begin
                  res.result_data    <= TIMEOUT_VAL;
                  res.result_timeout <= 1'b1;
                  res.result_valid   <= 1'b1;
                  state              <= PUBLISH;
               end else begin
                  counter <= cnt_inc;
               end
            end
            PUBLISH: begin
               if (xfer) begin
                  res.result_valid <= 1'b0;
                  if (DEADTIME_CYCLES == 0) begin
                     state <= arm ? ARMED : IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state    <= HOLDOFF;
                     hold_cnt <= HOLD_LOAD;
                  end
               end
            end
            HOLDOFF: begin
               if (hold_cnt == '0) begin
                  state <= arm ? ARMED : IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - HOLD_W'(1);
               end
            end
            default: begin
               state            <= IDLE;
               busy             <= 1'b0;
               res.result_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef MUON_TDC_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         event_count   <= '0;
         timeout_count <= '0;
      end else if (clear_stats) begin
         event_count   <= '0;
         timeout_count <= '0;
      end else if (xfer) begin
         event_count <= sat_inc(event_count);
         if (res.result_timeout) timeout_count <= sat_inc(timeout_count);
      end
   end
`endif

endmodule

// File: tb/tb_muon_tdc_sequencer.sv
module tb_muon_tdc_sequencer;
   import muon_tdc_pkg::*;

   localparam int TMO = 230;
   localparam int DT  = 16;

   typedef struct {
      int ready_lat;
      int stop_d;
      int exp_data;
      bit exp_to;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic        to;
   } res_t;

   logic clk = 1'b0;
   logic rst_n, arm, start_in, stop_in;
   logic busy;
   logic [2:0] state_dbg;
`ifdef MUON_TDC_STATS_EN
   logic clear_stats;
   logic [15:0] event_count, timeout_count;
`endif

   muon_tdc_sequencer_if #(.CNT_W(16)) bus ();

   muon_tdc_sequencer #(.TIMEOUT_CYCLES(TMO), .DEADTIME_CYCLES(DT), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .start_in(start_in), .stop_in(stop_in),
      .res(bus), .busy(busy), .state_dbg(state_dbg)
`ifdef MUON_TDC_STATS_EN
      , .clear_stats(clear_stats), .event_count(event_count), .timeout_count(timeout_count)
`endif
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   int   n_xfer = 0;
   int   pub_cycles = 0;
   res_t exp_q[$];
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] st, input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         @(negedge clk);
         if (state_dbg == st) break;
      end
      if (i == limit) chk("wait_state_timeout", state_dbg, st);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int limit);
      int i;
      for (i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.result_valid) break;
      end
      if (i == limit) chk("wait_valid_timeout", bus.result_valid, 1);
   endtask

   task automatic push_exp(input int d, input bit to);
      res_t e;
      e.data = 16'(d);
      e.to   = to;
      exp_q.push_back(e);
   endtask

   task automatic do_vec(input vec_t v);
      wait_state(ARMED, 60);
      bus.result_ready = (v.ready_lat == 0);
      push_exp(v.exp_data, v.exp_to);
      start_in = 1'b1;
      if (v.stop_d != 0) begin
         for (int c = 1; c <= v.stop_d; c++) begin
            step(1);
            start_in = 1'b0;
            stop_in  = (c == v.stop_d);
         end
         step(1);
         stop_in = 1'b0;
      end else begin
         step(1);
         start_in = 1'b0;
      end
      pub_cycles = 0;
      wait_valid(TMO + 20);
      if (v.ready_lat > 0) begin
         repeat (v.ready_lat) @(posedge clk);
         #1 bus.result_ready = 1'b1;
      end
      @(posedge clk);
      #1 bus.result_ready = 1'b0;
      @(negedge clk);
      chk("publish_cycles", pub_cycles, v.ready_lat + 1);
   endtask

   // scoreboard: each accepted transfer is checked against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && bus.result_valid) pub_cycles++;
      if (rst_n && bus.result_valid && bus.result_ready) begin
         n_xfer++;
         if (exp_q.size() == 0) begin
            chk("unexpected_xfer", bus.result_data, 16'hFFFF);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("xfer_data", bus.result_data, e.data);
            chk("xfer_timeout", bus.result_timeout, e.to);
         end
      end
   end

   initial begin
      vecs[0] = '{0, 47, 47, 1'b0};
      vecs[1] = '{3, 1, 1, 1'b0};
      vecs[2] = '{0, 2, 2, 1'b0};
      vecs[3] = '{5, TMO - 1, TMO - 1, 1'b0};
      vecs[4] = '{0, TMO, TMO, 1'b0};
      vecs[5] = '{2, 0, TMO, 1'b1};
      vecs[6] = '{1, 100, 100, 1'b0};

      rst_n = 1'b0; arm = 1'b0; start_in = 1'b0; stop_in = 1'b0;
      bus.result_ready = 1'b0;
`ifdef MUON_TDC_STATS_EN
      clear_stats = 1'b0;
`endif
      step(3);
      chk("rst_state", state_dbg, IDLE);
      chk("rst_busy", busy, 0);
      chk("rst_valid", bus.result_valid, 0);
      chk("rst_data", bus.result_data, 0);
      chk("rst_timeout", bus.result_timeout, 0);
      rst_n = 1'b1;
      step(2);
      chk("idle_no_arm", state_dbg, IDLE);

      // arm, then stop at D=47 with latency check
      arm = 1'b1;
      step(1);
      chk("armed_next_cycle", state_dbg, ARMED);
      push_exp(47, 1'b0);
      start_in = 1'b1;
      step(1); start_in = 1'b0;
      step(46); stop_in = 1'b1;
      step(1); stop_in = 1'b0;
      @(negedge clk);
      chk("lat_valid_early", bus.result_valid, 0);
      @(negedge clk);
      chk("lat_valid", bus.result_valid, 1);
      chk("lat_state", state_dbg, PUBLISH);
      chk("lat_busy", busy, 1);
      @(posedge clk); #1 bus.result_ready = 1'b1;
      @(posedge clk); #1 bus.result_ready = 1'b0;

      for (int i = 0; i < 7; i++) do_vec(vecs[i]);

      // retrigger: starts at 0 and 20, stop at 40 -> 20
      wait_state(ARMED, 60);
      bus.result_ready = 1'b1;
      push_exp(20, 1'b0);
      start_in = 1'b1;
      step(1);  start_in = 1'b0;
      step(19); start_in = 1'b1;
      step(1);  start_in = 1'b0;
      step(19); stop_in = 1'b1;
      step(1);  stop_in = 1'b0;
      wait_valid(60);
      @(posedge clk); #1 bus.result_ready = 1'b0;

      // start and stop together in ARMED: start taken, later stop at D=10
      wait_state(ARMED, 60);
      bus.result_ready = 1'b1;
      push_exp(10, 1'b0);
      start_in = 1'b1; stop_in = 1'b1;
      step(1); start_in = 1'b0; stop_in = 1'b0;
      step(9); stop_in = 1'b1;
      step(1); stop_in = 1'b0;
      wait_valid(60);
      @(posedge clk); #1 bus.result_ready = 1'b0;

      // start and stop together in MEASURE: stop wins at D=15
      wait_state(ARMED, 60);
      bus.result_ready = 1'b1;
      push_exp(15, 1'b0);
      start_in = 1'b1;
      step(1);  start_in = 1'b0;
      step(14); start_in = 1'b1; stop_in = 1'b1;
      step(1);  start_in = 1'b0; stop_in = 1'b0;
      wait_valid(60);
      @(posedge clk); #1 bus.result_ready = 1'b0;

      // backpressure: 100 cycles with injected pulses, then holdoff length
      begin
         int bad, hcnt;
         bad = 0;
         wait_state(ARMED, 60);
         push_exp(30, 1'b0);
         start_in = 1'b1;
         step(1);  start_in = 1'b0;
         step(29); stop_in = 1'b1;
         step(1);  stop_in = 1'b0;
         wait_valid(60);
         for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            start_in = i[2];
            stop_in  = i[3];
            @(negedge clk);
            if (bus.result_data != 16'd30 || bus.result_timeout || !bus.result_valid ||
                state_dbg != PUBLISH) bad++;
         end
         chk("bp_stable", bad, 0);
         chk("bp_busy", busy, 1);
         @(posedge clk); #1 bus.result_ready = 1'b1; start_in = 1'b0; stop_in = 1'b0;
         @(posedge clk); #1 bus.result_ready = 1'b0;
         hcnt = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state_dbg != HOLDOFF) break;
            hcnt++;
         end
         chk("holdoff_len", hcnt, DT);
         chk("after_holdoff", state_dbg, ARMED);
         chk("after_holdoff_busy", busy, 0);
         chk("bp_one_xfer", exp_q.size(), 0);
      end

      // arm dropped mid-measure: completes, then returns to IDLE
      wait_state(ARMED, 60);
      bus.result_ready = 1'b1;
      push_exp(20, 1'b0);
      start_in = 1'b1;
      step(1);  start_in = 1'b0;
      step(4);  arm = 1'b0;
      step(15); stop_in = 1'b1;
      step(1);  stop_in = 1'b0;
      wait_valid(60);
      @(posedge clk); #1 bus.result_ready = 1'b0;
      step(DT + 3);
      chk("disarm_idle", state_dbg, IDLE);
      chk("hold_data", bus.result_data, 20);
      arm = 1'b1;

      // reset mid-measure with start held high through release
      wait_state(ARMED, 60);
      start_in = 1'b1;
      step(10);
      chk("pre_rst_measure", state_dbg, MEASURE);
      rst_n = 1'b0;
      #2;
      chk("mid_rst_state", state_dbg, IDLE);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", bus.result_data, 0);
      chk("mid_rst_valid", bus.result_valid, 0);
      step(2);
      rst_n = 1'b1;
      step(6);
      chk("post_rst_no_start", state_dbg, ARMED);
      chk("post_rst_busy", busy, 0);
      start_in = 1'b0;
      step(2);

      // three events, one timeout (statistics start from the reset above)
      do_vec(vecs[0]);
      do_vec(vecs[5]);
      do_vec(vecs[2]);
`ifdef MUON_TDC_STATS_EN
      chk("event_count", event_count, 3);
      chk("timeout_count", timeout_count, 1);
      wait_state(ARMED, 60);
      push_exp(12, 1'b0);
      start_in = 1'b1;
      step(1);  start_in = 1'b0;
      step(11); stop_in = 1'b1;
      step(1);  stop_in = 1'b0;
      wait_valid(60);
      @(posedge clk); #1 bus.result_ready = 1'b1; clear_stats = 1'b1;
      @(posedge clk); #1 bus.result_ready = 1'b0; clear_stats = 1'b0;
      chk("clear_event_count", event_count, 0);
      chk("clear_timeout_count", timeout_count, 0);
`endif

      step(DT + 5);
      chk("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/muon_tdc_sequencer.md
Name: muon_tdc_sequencer

Overview:
- Run-control FSM for the decay-time TDC path. It arms the measurement, converts coincidence and stop hits into start/stop events, and counts the interval.
- Applies timeout and post-event dead time, then hands one result per event to the display/readout logic over a valid/ready handshake.
- Sits between the synchronized, debounced detector/button inputs and the BCD display path. Makes the TDC path restartable and lossless toward slow consumers.

Parameters:
- TIMEOUT_CYCLES, 230: max interval in clocks; result saturates here. Legal range 1..65535.
- DEADTIME_CYCLES, 16: clocks ignored after each published result before re-arming. 0 = re-arm immediately.
- CNT_W, 16: interval counter and result width.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- arm  in  1  level; run enable
- start_in  in  1  coincidence level, already synchronized
- stop_in  in  1  stop hit/button level, already synchronized and debounced
- result_data  out  CNT_W  measured interval in clocks
- result_timeout  out  1  result is a timeout (result_data = TIMEOUT_CYCLES)
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts
- busy  out  1  high in MEASURE, PUBLISH or HOLDOFF
- state_dbg  out  3  encoded current state

Behaviour:
- Edge detection:
  - start_in and stop_in each go through a registered rising-edge detector, giving 1-cycle pulses start_p and stop_p.
  - Both paths have equal latency.
- Reset:
  - state = IDLE; counter = 0.
  - result_data = 0, result_timeout = 0, result_valid = 0, busy = 0.
  - Edge-detector history registers = 0. A level already high when reset is released is not an edge.
- IDLE: arm = 1 -> ARMED (next cycle).
- ARMED:
  - start_p -> MEASURE; counter <= 0.
  - stop_p alone is ignored.
  - arm = 0 -> IDLE.
  - start_p and stop_p in the same cycle: start taken, stop ignored.
- MEASURE:
  - Counter increments once per cycle.
  - Result value: if start_in rises at sample edge t0 and stop_in rises at t0+D, result_data = D (D ≥ 1).
  - stop_p -> capture, result_timeout = 0 -> PUBLISH.
  - If D reaches TIMEOUT_CYCLES without a stop: result_data = TIMEOUT_CYCLES, result_timeout = 1 -> PUBLISH.
  - Stop arriving at exactly D = TIMEOUT_CYCLES is treated as a stop (timeout flag 0).
  - start_p in MEASURE (retrigger): counter restarts at 0; the interval is measured from the newest start.
  - stop_p and start_p in the same cycle: stop wins and the result is published.
  - arm deassert mid-measure: the measurement completes normally.
  - Counter never wraps; it is bounded by TIMEOUT_CYCLES.
- PUBLISH:
  - result_valid = 1. result_data and result_timeout are held stable until result_valid && result_ready.
  - Transfer cycle -> HOLDOFF, result_valid deasserted the next cycle.
  - start_p and stop_p are ignored; no queueing.
  - result_ready high on the first valid cycle gives a 1-cycle PUBLISH.
- HOLDOFF:
  - Counts DEADTIME_CYCLES clocks, ignoring all pulses. Then -> ARMED if arm = 1, else IDLE.
  - DEADTIME_CYCLES = 0 skips HOLDOFF (PUBLISH -> ARMED/IDLE directly).
- result_data and result_timeout keep the last published value outside PUBLISH, so the display holds it.
- Latency: stop_p to result_valid = 1 cycle.

Optional Feature:
- Macro: MUON_TDC_STATS_EN.
- Defined:
  - Adds input clear_stats (1 bit, synchronous, single-cycle).
  - Adds outputs event_count[15:0] and timeout_count[15:0].
  - Both counters increment on each handshake transfer; timeout_count only when result_timeout = 1.
  - Both saturate at 16'hFFFF. Reset and clear_stats set them to 0.
  - clear_stats and an increment in the same cycle: clear wins.
- Undefined: ports absent, no logic; all other behaviour identical.

Decomposition:
- Package muon_tdc_pkg holds:
  - the state enum: IDLE = 0, ARMED = 1, MEASURE = 2, PUBLISH = 3, HOLDOFF = 4;
  - CNT_W default;
  - a helper constant for the stats counter width.
- One natural sub-module: the codebase's rising_edge_detector, instantiated twice (start, stop), extended with async active-low reset.
- FSM, counter and handshake stay in a single module.

Test Plan:
- arm = 1; start_in rises at cycle 10, stop_in at cycle 57 -> result_data = 47, result_timeout = 0, result_valid 1 cycle after stop_p.
- arm = 1; start only, TIMEOUT_CYCLES = 230 -> result_data = 230, result_timeout = 1. Stop at exactly D = 230 -> result_data = 230, result_timeout = 0.
- Retrigger: start at 10, second start at 30, stop at 50 -> result_data = 20.
- Backpressure: result_ready held low 100 cycles, extra start/stop pulses injected -> data stable, pulses ignored; one transfer; HOLDOFF lasts 16 cycles before ARMED.
- Reset: rst_n low mid-MEASURE (and with start_in held high through release) -> all outputs 0, state IDLE, no spurious start after release.
- MUON_TDC_STATS_EN: 3 events (1 timeout) -> event_count = 3, timeout_count = 1. clear_stats coincident with a transfer -> both 0.
